fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded at reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: PCsrc  input  2  next-PC select from control unit: 0 PC+4, 1 PC+imm, 2 rs1_data+imm, 3 reserved.
REQ-005 Port: imm  input  32  sign-extended immediate for branch/jal/jalr.
REQ-006 Port: rs1_data  input  32  register rs1 value for jalr.
REQ-007 Port: im_req  output  1  instruction memory read request.
REQ-008 Port: im_addr  output  32  instruction memory byte address.
REQ-009 Port: im_ready  input  1  memory returns im_rdata this cycle.
REQ-010 Port: im_rdata  input  32  instruction word from memory.
REQ-011 Port: im_data  output  32  instruction register, consumed by control unit.
REQ-012 Port: inst_valid  output  1  im_data is in its execute cycle.
REQ-013 Port: pc  output  32  address of instruction in im_data.
REQ-014 Port: pc_plus4  output  32  pc+4, link value for jal/jalr.
REQ-015 Port: halted  output  1  EBREAK retired; fetch stopped.
REQ-016 Port: misaligned  output  1  halt caused by target address with [1:0] != 0.

Function
REQ-017 FSM states FETCH, EXEC, HALT SHALL be the only states; FETCH SHALL be entered on the first edge after rst_n deasserts.
REQ-018 FETCH: im_req=1, im_addr=pc held stable until im_ready=1; im_ready SHALL be ignored outside FETCH.
REQ-019 FETCH with im_ready=1: im_data <= im_rdata, next state EXEC; minimum 2 cycles per instruction.
REQ-020 EXEC: inst_valid=1 for exactly one cycle; im_req=0; PCsrc, imm and rs1_data sampled this cycle only.
REQ-021 EXEC next PC: PCsrc 0 or 3 -> pc+4; 1 -> pc+imm; 2 -> (rs1_data+imm) with bit 0 cleared; all 32-bit modulo arithmetic (0xFFFF_FFFC+4 = 0).
REQ-022 EXEC with im_data[6:0]=7'b1110011: pc unchanged, next state HALT, halted=1.
REQ-023 EXEC with next-PC[1:0] != 0: pc unchanged, next state HALT, halted=1, misaligned=1.
REQ-024 Otherwise EXEC: pc <= next PC, next state FETCH.
REQ-025 HALT is sticky until rst_n asserted; no requests, inst_valid=0, all outputs frozen.
REQ-026 pc_plus4 SHALL equal pc+4 combinationally in every state.

Reset
REQ-027 rst_n low SHALL immediately force: pc=RESET_PC, im_data=32'h0000_0013 (NOP), inst_valid=0, im_req=0, halted=0, misaligned=0, state FETCH-pending.
REQ-028 Reset during an outstanding FETCH SHALL drop im_req asynchronously; a late im_ready after reset SHALL not update im_data.

Structure
REQ-029 Package riscv_pkg SHALL hold opcode constants (incl. EBREAK 7'b1110011), PCsrc encodings, NOP constant and the FSM state enum, shared with control_unit.
REQ-030 One combinational sub-module pc_next_logic SHALL compute next PC and misalignment flag; fetch_unit holds FSM and registers.

Verification
REQ-031 Reset, im_ready tied 1, im_rdata=NOP, PCsrc=0 -> im_addr sequence 0x0,0x4,0x8, inst_valid every 2nd cycle.
REQ-032 im_ready delayed 3 cycles -> im_req and im_addr=0x4 held stable 4 cycles; one inst_valid pulse after capture.
REQ-033 pc=0x10, PCsrc=1, imm=0xFFFF_FFF8 -> next im_addr 0x08; PCsrc=2, rs1=0x101, imm=0x3 -> im_addr 0x104.
REQ-034 im_rdata=32'h0010_0073 (EBREAK) at pc=0x20 -> halted=1, pc stays 0x20, no further im_req for 10 cycles.
REQ-035 PCsrc=1, pc=0x0, imm=0x6 -> halted=1, misaligned=1, pc=0x0; then rst_n pulse -> im_addr=RESET_PC, flags 0.
REQ-036 rst_n asserted mid-FETCH with im_ready rising same cycle -> im_data=NOP, pc=RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 fetch/control definitions: opcodes, next-PC select codes, NOP and fetch FSM states.
// Imported by fetch_unit, pc_next_logic and the control unit.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_EBREAK = 7'b1110011;

    localparam logic [1:0] PCSRC_PLUS4   = 2'd0;
    localparam logic [1:0] PCSRC_IMM     = 2'd1;
    localparam logic [1:0] PCSRC_RS1_IMM = 2'd2;
    localparam logic [1:0] PCSRC_RSVD    = 2'd3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    function automatic logic is_ebreak(input logic [31:0] inst);
        return inst[6:0] == OPC_EBREAK;
    endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC mux: PC+4, PC+imm or (rs1+imm) with bit 0 cleared, plus word-misalignment flag.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module pc_next_logic
    import riscv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    always_comb begin
        next_pc = pc + 32'd4;
        case (pc_src)
            PCSRC_IMM:     next_pc = pc + imm;
            PCSRC_RS1_IMM: next_pc = (rs1_data + imm) & ~32'd1;
            default:       next_pc = pc + 32'd4;
        endcase
        misaligned = (next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: requests im_addr=pc, latches the word, presents it for one execute cycle.
// Latency: at least 2 cycles per instruction (FETCH until im_ready, then one EXEC cycle).
// Backpressure: im_req and im_addr held stable until im_ready; HALT is sticky until reset.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  PCsrc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_rdata,
    output logic [31:0] im_data,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        misaligned
);

    fetch_state_e state;
    logic [31:0]  next_pc;
    logic         next_misaligned;

    pc_next_logic u_pc_next (
        .pc         (pc),
        .pc_src     (PCsrc),
        .imm        (imm),
        .rs1_data   (rs1_data),
        .next_pc    (next_pc),
        .misaligned (next_misaligned)
    );

    assign im_addr  = pc;
    assign pc_plus4 = pc + 32'd4;

    // Reset leaves FETCH with im_req low; the first edge after release raises it,
    // so a stale im_ready arriving around reset can never load im_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            im_data    <= NOP_INSTR;
            im_req     <= 1'b0;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!im_req) begin
                        im_req <= 1'b1;
                    end else if (im_ready) begin
                        im_data    <= im_rdata;
                        im_req     <= 1'b0;
                        inst_valid <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    inst_valid <= 1'b0;
                    if (is_ebreak(im_data)) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else if (next_misaligned) begin
                        halted     <= 1'b1;
                        misaligned <= 1'b1;
                        state      <= HALT;
                    end else begin
                        pc     <= next_pc;
                        im_req <= 1'b1;
                        state  <= FETCH;
                    end
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

endmodule
